timer_rd_snap: RTL and testbench
================================

// Module: timer_rd_snap
// PURPOSE
// APB read-side companion to the 64-bit timer counter. Returns the TCR, TDR0 and TDR1 values
// on prdata, and generates pready/pslverr for every timer transfer.
// Reading TDR0 captures all 64 bits of count into a snapshot, so a following TDR1 read
// returns the upper word belonging to the same instant (coherent 64-bit read).
// Sits between the APB slave port and the counter, alongside the write-side register logic.
// PARAMETERS
// ADDR_W     12      width of paddr
// TCR_ADDR   12'h000 control register offset
// TDR0_ADDR  12'h004 counter low word offset
// TDR1_ADDR  12'h008 counter high word offset
// PORTS
// clk        in   1       single clock, all flops rising edge
// rst        in   1       asynchronous, active-high reset
// psel       in   1       APB select
// penable    in   1       APB enable
// pwrite     in   1       1 = write, 0 = read
// paddr      in   ADDR_W  APB address
// count      in   64      live counter value
// timer_en   in   1       TCR[0] source
// div_en     in   1       TCR[1] source
// div_val    in   4       TCR[11:8] source
// wr_DR0     in   1       write strobe to TDR0 (invalidates snapshot)
// wr_DR1     in   1       write strobe to TDR1 (invalidates snapshot)
// prdata     out  32      registered read data
// pready     out  1       transfer complete
// pslverr    out  1       transfer error, valid only while pready=1
// BEHAVIOUR
// Reset values: prdata=0, pready=0, pslverr=0, snap=0, snap_vld=0, FSM=IDLE.
// Clock and reset: one clock domain; reset is asynchronous, active-high.
// FSM
// - IDLE -> WAIT on psel & !penable (setup phase).
// - WAIT -> DONE on psel & penable; pready=0 in WAIT.
//   The read-data mux and snapshot are sampled on this edge.
// - DONE: pready=1 for exactly one cycle -> IDLE.
// - Latency: setup + 2 access cycles; pready always asserted on the 2nd penable-high cycle.
// - psel dropped in WAIT -> IDLE; no prdata, snap or snap_vld update; pready stays 0.
// Read mux (sampled at WAIT exit, held in prdata until the next DONE)
// - TCR: {20'b0, div_val, 6'b0, div_en, timer_en}.
// - TDR0: returns count[31:0]; snap <= count (all 64 bits, same edge); snap_vld <= 1.
// - TDR1 with snap_vld=1: returns snap[63:32]; snap_vld <= 0.
// - TDR1 with snap_vld=0: returns live count[63:32].
// Errors
// - Any other offset, or paddr[1:0] != 0 -> prdata=0 and pslverr=1 in DONE.
//   Applies to reads and writes.
// - Writes to valid offsets: pslverr=0; prdata unchanged.
// Snapshot invalidation
// - wr_DR0 or wr_DR1 in any cycle -> snap_vld <= 0.
// - Invalidation wins over a same-cycle TDR0 capture: snap is loaded, snap_vld ends 0.
// Count wrap: 64'hFFFF_FFFF_FFFF_FFFF -> 0 between the TDR0 and TDR1 reads is invisible;
//   the snapshot is returned.
// Reset asserted mid-transfer: immediate return to IDLE with all reset values; a pending
//   transfer never completes.
// Outside DONE: pready=0 and pslverr=0.
// STRUCTURE
// Shared package timer_pkg: register offsets, TCR bit positions, FSM state encoding
//   (IDLE=2'd0, WAIT=2'd1, DONE=2'd2).
// One sub-module, timer_snap_reg: 64-bit snap plus snap_vld, with the capture/consume/
//   invalidate priority described above.
// Top level holds the FSM, the address decode and the prdata mux.
// TESTING
// 1. Reset: rst=1 mid-WAIT -> pready=0, prdata=0, snap_vld=0 the same cycle; next setup
//    completes normally.
// 2. Coherent read: count=64'h0000_0001_FFFF_FFFE, read TDR0, count advances past the 32-bit
//    boundary, read TDR1 -> prdata=32'hFFFF_FFFE then 32'h0000_0001.
// 3. Bare TDR1 read (snap_vld=0), count=64'hA5A5_0000_0000_0000 -> prdata=32'hA5A5_0000.
// 4. Invalidate: read TDR0, pulse wr_DR1, read TDR1 -> live upper word returned, not the snap.
// 5. TCR read: timer_en=1, div_en=1, div_val=4'h3 -> prdata=32'h0000_0303, pready on the 2nd
//    access cycle.
// 6. Bad access: read 12'h00C and read 12'h006 -> pslverr=1, prdata=0.
//    Write 12'h004 -> pslverr=0.

Source files
------------

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared timer register offsets, TCR bit layout and APB FSM encoding
package timer_pkg;

    localparam logic [11:0] TCR_OFF  = 12'h000;
    localparam logic [11:0] TDR0_OFF = 12'h004;
    localparam logic [11:0] TDR1_OFF = 12'h008;

    localparam int TCR_TEN_BIT = 0;
    localparam int TCR_DEN_BIT = 1;
    localparam int TCR_DIV_LSB = 8;
    localparam int TCR_DIV_W   = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } apb_state_t;

endpackage

// File: rtl/timer_snap_reg.sv
// rtl/timer_snap_reg.sv - 64-bit counter snapshot with capture/consume/invalidate valid flag
module timer_snap_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        capture,
    input  logic        consume,
    input  logic        invalidate,
    input  logic [63:0] count,
    output logic [63:0] snap,
    output logic        snap_vld
);

    // snap is loaded even when a same-cycle invalidate kills the valid flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap     <= '0;
            snap_vld <= 1'b0;
        end else begin
            if (capture) begin
                snap <= count;
            end
            if (invalidate) begin
                snap_vld <= 1'b0;
            end else if (capture) begin
                snap_vld <= 1'b1;
            end else if (consume) begin
                snap_vld <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/timer_rd_snap.sv
// rtl/timer_rd_snap.sv - APB read side of the 64-bit timer with coherent TDR0/TDR1 reads
module timer_rd_snap
    import timer_pkg::*;
#(
    parameter int                ADDR_W    = 12,
    parameter logic [ADDR_W-1:0] TCR_ADDR  = ADDR_W'(TCR_OFF),
    parameter logic [ADDR_W-1:0] TDR0_ADDR = ADDR_W'(TDR0_OFF),
    parameter logic [ADDR_W-1:0] TDR1_ADDR = ADDR_W'(TDR1_OFF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [63:0]       count,
    input  logic              timer_en,
    input  logic              div_en,
    input  logic [3:0]        div_val,
    input  logic              wr_DR0,
    input  logic              wr_DR1,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr
);

    apb_state_t  state_q;
    apb_state_t  state_d;
    logic        sample;
    logic        is_tcr;
    logic        is_dr0;
    logic        is_dr1;
    logic        addr_ok;
    logic        err_q;
    logic [31:0] tcr_word;
    logic [31:0] rd_mux;
    logic [63:0] snap;
    logic        snap_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // sample marks the WAIT->DONE edge, where read data and the snapshot are taken
    always_comb begin
        state_d = state_q;
        sample  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (psel && !penable) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!psel) begin
                    state_d = S_IDLE;
                end else if (penable) begin
                    state_d = S_DONE;
                    sample  = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign is_tcr  = (paddr == TCR_ADDR);
    assign is_dr0  = (paddr == TDR0_ADDR);
    assign is_dr1  = (paddr == TDR1_ADDR);
    assign addr_ok = (paddr[1:0] == 2'b00) && (is_tcr || is_dr0 || is_dr1);

    always_comb begin
        tcr_word = '0;
        tcr_word[TCR_TEN_BIT] = timer_en;
        tcr_word[TCR_DEN_BIT] = div_en;
        tcr_word[TCR_DIV_LSB +: TCR_DIV_W] = div_val;
    end

    always_comb begin
        rd_mux = '0;
        if (is_tcr) begin
            rd_mux = tcr_word;
        end else if (is_dr0) begin
            rd_mux = count[31:0];
        end else if (snap_vld) begin
            rd_mux = snap[63:32];
        end else begin
            rd_mux = count[63:32];
        end
    end

    timer_snap_reg u_snap (
        .clk        (clk),
        .rst        (rst),
        .capture    (sample && !pwrite && addr_ok && is_dr0),
        .consume    (sample && !pwrite && addr_ok && is_dr1 && snap_vld),
        .invalidate (wr_DR0 || wr_DR1),
        .count      (count),
        .snap       (snap),
        .snap_vld   (snap_vld)
    );

    // valid writes leave prdata holding the last read value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prdata <= '0;
            err_q  <= 1'b0;
        end else if (sample) begin
            if (!addr_ok) begin
                prdata <= '0;
                err_q  <= 1'b1;
            end else begin
                err_q <= 1'b0;
                if (!pwrite) begin
                    prdata <= rd_mux;
                end
            end
        end
    end

    assign pready  = (state_q == S_DONE);
    assign pslverr = pready && err_q;

endmodule

// File: tb/tb_timer_rd_snap.sv
// tb/tb_timer_rd_snap.sv - vector table, corner sequences and randomized model check for timer_rd_snap
module tb_timer_rd_snap;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [11:0] paddr;
    logic [63:0] count;
    logic        timer_en;
    logic        div_en;
    logic [3:0]  div_val;
    logic        wr_DR0;
    logic        wr_DR1;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] m_snap;
    logic        m_vld;
    logic [31:0] m_prdata;

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [63:0] cnt;
        logic        ten;
        logic        den;
        logic [3:0]  dv;
        logic [1:0]  pre_wr;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[15];

    timer_rd_snap dut (
        .clk      (clk),
        .rst      (rst),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .count    (count),
        .timer_en (timer_en),
        .div_en   (div_en),
        .div_val  (div_val),
        .wr_DR0   (wr_DR0),
        .wr_DR1   (wr_DR1),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_snap   = '0;
        m_vld    = 1'b0;
        m_prdata = '0;
    endtask

    // Register-level view: what a software reader of TCR/TDR0/TDR1 should observe
    task automatic model_xfer(input logic wr, input logic [11:0] addr, input logic inval,
                              output logic [31:0] e_rd, output logic e_err);
        bit known;
        known = (addr == 12'h000) || (addr == 12'h004) || (addr == 12'h008);
        e_err = !known;
        if (!known) begin
            m_prdata = 32'h0;
        end else if (!wr) begin
            if (addr == 12'h000) begin
                m_prdata = 32'(div_val) * 256 + 32'(div_en) * 2 + 32'(timer_en);
            end else if (addr == 12'h004) begin
                m_prdata = count[31:0];
                m_snap   = count;
                m_vld    = 1'b1;
            end else begin
                m_prdata = m_vld ? m_snap[63:32] : count[63:32];
                m_vld    = 1'b0;
            end
        end
        if (inval) m_vld = 1'b0;
        e_rd = m_prdata;
    endtask

    task automatic pulse_wr(input logic [1:0] which);
        @(posedge clk); #1;
        wr_DR0 = which[0];
        wr_DR1 = which[1];
        @(posedge clk); #1;
        wr_DR0 = 1'b0;
        wr_DR1 = 1'b0;
        if (which != 2'b00) m_vld = 1'b0;
    endtask

    // Setup + two access cycles; wrdr is driven during the first access cycle
    task automatic xfer(input logic wr, input logic [11:0] addr, input logic [1:0] wrdr,
                        input string name, output logic [31:0] rd, output logic err,
                        output logic [31:0] e_rd, output logic e_err);
        model_xfer(wr, addr, wrdr != 2'b00, e_rd, e_err);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
        @(posedge clk); #1;
        penable = 1'b1; wr_DR0 = wrdr[0]; wr_DR1 = wrdr[1];
        @(negedge clk);
        check({name, " pready_acc1"}, 64'(pready), 64'd0);
        check({name, " pslverr_acc1"}, 64'(pslverr), 64'd0);
        @(posedge clk); #1;
        wr_DR0 = 1'b0; wr_DR1 = 1'b0;
        @(negedge clk);
        check({name, " pready_acc2"}, 64'(pready), 64'd1);
        rd  = prdata;
        err = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        check({name, " pready_after"}, 64'(pready), 64'd0);
        check({name, " pslverr_after"}, 64'(pslverr), 64'd0);
    endtask

    initial begin
        logic [31:0] rd, e_rd;
        logic        err, e_err;
        logic [11:0] addr;
        logic        wr;

        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
        count = '0; timer_en = 1'b0; div_en = 1'b0; div_val = '0;
        wr_DR0 = 1'b0; wr_DR1 = 1'b0;
        model_reset();

        vecs[0]  = '{1'b0, 12'h000, 64'h0,                   1'b1, 1'b1, 4'h3, 2'b00, 32'h0000_0303, 1'b0};
        vecs[1]  = '{1'b0, 12'h004, 64'h0000_0001_FFFF_FFFE, 1'b0, 1'b0, 4'h0, 2'b00, 32'hFFFF_FFFE, 1'b0};
        vecs[2]  = '{1'b0, 12'h008, 64'h0000_0002_0000_0003, 1'b0, 1'b0, 4'h0, 2'b00, 32'h0000_0001, 1'b0};
        vecs[3]  = '{1'b0, 12'h008, 64'hA5A5_0000_0000_0000, 1'b0, 1'b0, 4'h0, 2'b00, 32'hA5A5_0000, 1'b0};
        vecs[4]  = '{1'b0, 12'h004, 64'h1111_2222_3333_4444, 1'b0, 1'b0, 4'h0, 2'b00, 32'h3333_4444, 1'b0};
        vecs[5]  = '{1'b0, 12'h008, 64'h5555_6666_7777_8888, 1'b0, 1'b0, 4'h0, 2'b10, 32'h5555_6666, 1'b0};
        vecs[6]  = '{1'b0, 12'h00C, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0, 4'h0, 2'b00, 32'h0000_0000, 1'b1};
        vecs[7]  = '{1'b0, 12'h006, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0, 4'h0, 2'b00, 32'h0000_0000, 1'b1};
        vecs[8]  = '{1'b0, 12'h004, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 4'h0, 2'b00, 32'hFFFF_FFFF, 1'b0};
        vecs[9]  = '{1'b0, 12'h008, 64'h0000_0000_0000_0000, 1'b0, 1'b0, 4'h0, 2'b00, 32'hFFFF_FFFF, 1'b0};
        vecs[10] = '{1'b1, 12'h004, 64'h0000_0000_0000_0001, 1'b0, 1'b0, 4'h0, 2'b00, 32'hFFFF_FFFF, 1'b0};
        vecs[11] = '{1'b1, 12'h00C, 64'h0000_0000_0000_0002, 1'b0, 1'b0, 4'h0, 2'b00, 32'h0000_0000, 1'b1};
        vecs[12] = '{1'b1, 12'h000, 64'h0000_0000_0000_0003, 1'b1, 1'b0, 4'h9, 2'b00, 32'h0000_0000, 1'b0};
        vecs[13] = '{1'b0, 12'h004, 64'hDEAD_BEEF_0BAD_F00D, 1'b0, 1'b0, 4'h0, 2'b01, 32'h0BAD_F00D, 1'b0};
        vecs[14] = '{1'b0, 12'h008, 64'h1234_0000_0000_0000, 1'b0, 1'b1, 4'hF, 2'b00, 32'hDEAD_BEEF, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset prdata", 64'(prdata), 64'd0);
        check("reset pready", 64'(pready), 64'd0);
        check("reset pslverr", 64'(pslverr), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            count = vecs[i].cnt; timer_en = vecs[i].ten; div_en = vecs[i].den; div_val = vecs[i].dv;
            if (vecs[i].pre_wr != 2'b00) pulse_wr(vecs[i].pre_wr);
            xfer(vecs[i].wr, vecs[i].addr, 2'b00, $sformatf("vec%0d", i), rd, err, e_rd, e_err);
            check($sformatf("vec%0d prdata", i), 64'(rd), 64'(vecs[i].exp_rd));
            check($sformatf("vec%0d pslverr", i), 64'(err), 64'(vecs[i].exp_err));
        end

        // Invalidate in the same cycle as a TDR0 capture: next TDR1 returns the live word
        count = 64'hCAFE_0001_0000_0010;
        xfer(1'b0, 12'h004, 2'b01, "cap_inval", rd, err, e_rd, e_err);
        check("cap_inval prdata", 64'(rd), 64'h0000_0010);
        count = 64'hBEEF_0002_0000_0020;
        xfer(1'b0, 12'h008, 2'b00, "cap_inval_dr1", rd, err, e_rd, e_err);
        check("cap_inval_dr1 prdata", 64'(rd), 64'hBEEF_0002);

        // psel dropped in WAIT: no completion, no prdata or snapshot change
        count = 64'h0000_0007_0000_0009;
        xfer(1'b0, 12'h004, 2'b00, "abort_pre", rd, err, e_rd, e_err);
        check("abort_pre prdata", 64'(rd), 64'h0000_0009);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = 12'h008; pwrite = 1'b0;
        @(posedge clk); #1;
        psel = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("abort pready", 64'(pready), 64'd0);
        end
        check("abort prdata", 64'(prdata), 64'h0000_0009);
        count = 64'h0000_0008_0000_0000;
        xfer(1'b0, 12'h008, 2'b00, "abort_dr1", rd, err, e_rd, e_err);
        check("abort_dr1 prdata", 64'(rd), 64'h0000_0007);

        // Reset asserted mid-WAIT with a valid snapshot and nonzero prdata
        count = 64'h0123_4567_89AB_CDEF;
        xfer(1'b0, 12'h004, 2'b00, "rstmid_pre", rd, err, e_rd, e_err);
        check("rstmid_pre prdata", 64'(rd), 64'h89AB_CDEF);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = 12'h008;
        @(posedge clk); #1;
        penable = 1'b1;
        #1 rst = 1'b1;
        #1;
        check("rstmid pready", 64'(pready), 64'd0);
        check("rstmid prdata", 64'(prdata), 64'd0);
        check("rstmid pslverr", 64'(pslverr), 64'd0);
        psel = 1'b0; penable = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstmid no_complete", 64'(pready), 64'd0);
        count = 64'hA5A5_0000_0000_0000;
        xfer(1'b0, 12'h008, 2'b00, "rstmid_post", rd, err, e_rd, e_err);
        check("rstmid_post prdata", 64'(rd), 64'hA5A5_0000);

        // Randomized traffic against the register-level model
        for (int i = 0; i < 250; i++) begin
            count    = {$urandom(), $urandom()};
            timer_en = 1'($urandom());
            div_en   = 1'($urandom());
            div_val  = 4'($urandom());
            case ($urandom_range(0, 8))
                0, 1:    addr = 12'h004;
                2, 3:    addr = 12'h008;
                4:       addr = 12'h000;
                5:       addr = 12'h00C;
                6:       addr = 12'h005;
                default: addr = 12'($urandom());
            endcase
            wr = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) pulse_wr(2'($urandom_range(1, 3)));
            xfer(wr, addr, ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                 $sformatf("rnd%0d", i), rd, err, e_rd, e_err);
            check($sformatf("rnd%0d prdata a=%h w=%0d", i, addr, wr), 64'(rd), 64'(e_rd));
            check($sformatf("rnd%0d pslverr a=%h", i, addr), 64'(err), 64'(e_err));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
